// File: rtl/ts_switch_sequencer.sv
// Packet-aligned, glitch-free TS mux channel sequencer with timeout/loss forcing and hold-off.
// Optional `SWITCH_STATS_EN enables the saturating switch/forced statistics counters.
module ts_switch_sequencer #(
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_mux,
  input  logic [1:0]       req_channel,
  input  logic [3:0]       valid,
  input  logic [3:0]       pkt_start,
  output logic [1:0]       mux_sel,
  output logic             busy,
  output logic             switch_done,
  output logic             forced,
  output logic [CNT_W-1:0] switch_count,
  output logic [CNT_W-1:0] forced_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HC = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES : 1;
  localparam int HW = $clog2(HC) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(HC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          frc_q, frc_d;
  logic [1:0]    nt;
  logic          lost;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    tmr_d   = tmr_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    frc_d   = 1'b0;
    nt      = tgt_q;
    lost    = 1'b0;
    if (!en_mux) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sel_d   = req_channel;
          state_d = S_LOCKED;
        end
        S_LOCKED: begin
          if (req_channel != sel_q && valid[req_channel]) begin
            tgt_d   = req_channel;
            tmr_d   = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (req_channel == sel_q || !valid[tgt_q]) begin
            state_d = S_LOCKED;
          end else begin
            // A valid retarget takes effect in the same cycle as a boundary
            if (req_channel != tgt_q && valid[req_channel])
              nt = req_channel;
            tgt_d = nt;
            lost  = !valid[sel_q] || (tmr_q == TLAST);
            if (pkt_start[sel_q] || lost) begin
              sel_d   = nt;
              done_d  = 1'b1;
              frc_d   = lost;
              hcnt_d  = '0;
              state_d = (HOLDOFF_CYCLES == 0) ? S_LOCKED : S_HOLD;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
        end
        S_HOLD: begin
          if (hcnt_q == HLAST) state_d = S_LOCKED;
          else hcnt_d = hcnt_q + HW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_WAIT) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      tmr_q   <= '0;
      hcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      frc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      tmr_q   <= tmr_d;
      hcnt_q  <= hcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      frc_q   <= frc_d;
    end
  end

  assign mux_sel     = sel_q;
  assign busy        = busy_q;
  assign switch_done = done_q;
  assign forced      = frc_q;

`ifdef SWITCH_STATS_EN
  logic [CNT_W-1:0] swc_q, swc_d;
  logic [CNT_W-1:0] fcc_q, fcc_d;

  always_comb begin
    swc_d = swc_q;
    fcc_d = fcc_q;
    if (done_d && swc_q != '1) swc_d = swc_q + CNT_W'(1);
    if (frc_d && fcc_q != '1) fcc_d = fcc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swc_q <= '0;
      fcc_q <= '0;
    end else begin
      swc_q <= swc_d;
      fcc_q <= fcc_d;
    end
  end

  assign switch_count = swc_q;
  assign forced_count = fcc_q;
`else
  assign switch_count = '0;
  assign forced_count = '0;
`endif

endmodule

// File: tb/tb_ts_switch_sequencer.sv
// Randomized scoreboard bench for ts_switch_sequencer against a behavioural model.
// Builds with or without `SWITCH_STATS_EN; expected counters follow the same macro.
module tb_ts_switch_sequencer;

  localparam int HOLD  = 16;
  localparam int TO    = 100;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en_mux = 1'b0;
  logic [1:0]       req_channel = '0;
  logic [3:0]       valid = '0;
  logic [3:0]       pkt_start = '0;
  logic [1:0]       mux_sel;
  logic             busy;
  logic             switch_done;
  logic             forced;
  logic [CNT_W-1:0] switch_count;
  logic [CNT_W-1:0] forced_count;

  ts_switch_sequencer #(
    .HOLDOFF_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_mux(en_mux),
    .req_channel(req_channel),
    .valid(valid),
    .pkt_start(pkt_start),
    .mux_sel(mux_sel),
    .busy(busy),
    .switch_done(switch_done),
    .forced(forced),
    .switch_count(switch_count),
    .forced_count(forced_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       sel;
    logic             busy;
    logic             done;
    logic             frc;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;

  // Behavioural model: enabled flag, pending request, age and remaining hold-off.
  bit m_on, m_pend;
  int m_sel, m_tgt, m_age, m_hold, m_sc, m_fc;

  task automatic push_exp(input bit done, input bit frc);
    exp_t e;
    e.sel  = 2'(m_sel);
    e.busy = m_pend || (m_hold > 0);
    e.done = done;
    e.frc  = frc;
`ifdef SWITCH_STATS_EN
    e.sc = CNT_W'(m_sc);
    e.fc = CNT_W'(m_fc);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_sel = 0; m_tgt = 0;
    m_age = 0; m_hold = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit en, input int req,
                            input logic [3:0] v, input logic [3:0] p);
    bit done, frc, lost;
    done = 0; frc = 0;
    if (!en) begin
      m_on = 0; m_pend = 0; m_hold = 0;
    end else if (!m_on) begin
      m_sel = req; m_on = 1;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (!m_pend) begin
      if (req != m_sel && v[req]) begin
        m_pend = 1; m_tgt = req; m_age = 0;
      end
    end else if (req == m_sel || !v[m_tgt]) begin
      m_pend = 0;
    end else begin
      if (req != m_tgt && v[req]) m_tgt = req;
      lost = !v[m_sel] || (m_age == TO - 1);
      if (p[m_sel] || lost) begin
        m_sel = m_tgt; done = 1; frc = lost;
        m_pend = 0; m_hold = HOLD;
        if (m_sc < CMAX) m_sc++;
        if (lost && m_fc < CMAX) m_fc++;
      end else begin
        m_age++;
      end
    end
    push_exp(done, frc);
  endtask

  task automatic drive(input bit en, input logic [1:0] req,
                       input logic [3:0] v, input logic [3:0] p);
    @(negedge clk);
    rst = 1'b0;
    en_mux = en; req_channel = req; valid = v; pkt_start = p;
    model_step(en, int'(req), v, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_reset();
    push_exp(0, 0);
    @(negedge clk);
    push_exp(0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if ({mux_sel, busy, switch_done, forced, switch_count, forced_count} !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d got sel=%0d busy=%b done=%b frc=%b sc=%0d fc=%0d want sel=%0d busy=%b done=%b frc=%b sc=%0d fc=%0d",
                   cyc, mux_sel, busy, switch_done, forced, switch_count, forced_count,
                   e.sel, e.busy, e.done, e.frc, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : stim
    bit r_en;
    logic [1:0] r_req;
    logic [3:0] r_valid, r_pkt;
    bit quiet;
    do_reset();
    // Enable straight onto channel 2
    drive(1, 2'd2, 4'hF, 4'h0);
    repeat (3) drive(1, 2'd2, 4'hF, 4'h0);
    // Switch 2->1 aligned on a strobe of channel 2 after 40 cycles
    repeat (40) drive(1, 2'd1, 4'hF, 4'h0);
    drive(1, 2'd1, 4'hF, 4'h4);
    // Hold-off with request flipping to 0, then loss-forced switch
    repeat (20) drive(1, 2'd0, 4'hF, 4'h0);
    drive(1, 2'd3, 4'hF, 4'h0);
    drive(1, 2'd3, 4'hD, 4'h0);
    repeat (HOLD + 2) drive(1, 2'd3, 4'hD, 4'h0);
    // Timeout-forced switch with no strobes
    repeat (TO + 5) drive(1, 2'd0, 4'hF, 4'h0);
    repeat (HOLD + 2) drive(1, 2'd0, 4'hF, 4'h0);
    // Abort via request return, then via disable
    drive(1, 2'd2, 4'hF, 4'h0);
    drive(1, 2'd2, 4'hF, 4'h0);
    drive(1, 2'd0, 4'hF, 4'h0);
    drive(1, 2'd2, 4'hF, 4'h0);
    drive(0, 2'd2, 4'hF, 4'h1);
    drive(1, 2'd1, 4'hF, 4'h0);
    // Strobe on target only is irrelevant
    drive(1, 2'd3, 4'hF, 4'h0);
    drive(1, 2'd3, 4'hF, 4'h8);
    drive(1, 2'd3, 4'hF, 4'h2);
    r_en = 1; r_req = 2'd0; r_valid = 4'hF;
    for (int i = 0; i < 20000; i++) begin
      quiet = ((i / 1500) % 3) == 2;
      if ($urandom_range(0, 3999) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) r_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) r_valid[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 29) == 0) r_valid = 4'hF;
      if (r_en && $urandom_range(0, 499) == 0) r_en = 0;
      else if (!r_en && $urandom_range(0, 4) == 0) r_en = 1;
      r_pkt = '0;
      for (int c = 0; c < 4; c++)
        if (!quiet && $urandom_range(0, 59) == 0) r_pkt[c] = 1'b1;
      drive(r_en, r_req, r_valid, r_pkt);
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
